// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory load/store port.
// Runs one byte, halfword or word access at a time. Sub-word stores are done
// as read-modify-write of the 32-bit word. Loads are sign- or zero-extended.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE. A request that is
// presented while the unit is busy is not queued; it is taken only once the
// unit is back in IDLE and req_valid is still high. resp_valid is a
// single-cycle pulse. resp_err and resp_rdata hold until the next response.
module load_store_unit #(
  parameter int MEM_WORDS  = 32,
  parameter int WORD_IDX_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        data_read_flag,
  output logic        data_write_flag,
  output logic [31:0] data_addr,
  output logic [31:0] val,
  input  logic [31:0] read_out
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  // The limit is compared at 33 bits so that every upper address bit is
  // checked and nothing aliases into the array.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t      state;
  logic        store_q;
  logic        unsigned_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] old_q;
  logic        req_err;
  logic [31:0] shifted;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic [WORD_IDX_W-1:0] word_idx;

  // Reject an illegal size, a misaligned address or an out-of-range address.
  always_comb begin
    req_err = 1'b0;
    if (req_size == 2'b11)                        req_err = 1'b1;
    if ((req_size == 2'b01) && req_addr[0])       req_err = 1'b1;
    if ((req_size == 2'b10) && (|req_addr[1:0]))  req_err = 1'b1;
    if ({1'b0, req_addr} >= ADDR_LIMIT)           req_err = 1'b1;
  end

  // Pick the addressed lane out of the memory word and extend it.
  always_comb begin
    shifted   = read_out >> {addr_q[1:0], 3'b000};
    load_data = read_out;
    case (size_q)
      2'b00:   load_data = unsigned_q ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = unsigned_q ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = read_out;
    endcase
  end

  // Store data: replace only the addressed lane of the old word.
  always_comb begin
    merged = old_q;
    case (size_q)
      2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      2'b01:   merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Request acceptance, sequencing and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      store_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      old_q      <= 32'h0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            store_q    <= req_store;
            unsigned_q <= req_unsigned;
            size_q     <= req_size;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            if (req_err) begin
              state      <= DONE;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_store && (req_size == 2'b10)) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          old_q <= read_out;
          if (store_q) begin
            state <= WR;
          end else begin
            state      <= DONE;
            resp_err   <= 1'b0;
            resp_rdata <= load_data;
          end
        end
        WR: begin
          state      <= DONE;
          resp_err   <= 1'b0;
          resp_rdata <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side and handshake outputs decode from the registered state.
  always_comb begin
    word_idx        = addr_q[WORD_IDX_W+1:2];
    req_ready       = (state == IDLE);
    resp_valid      = (state == DONE);
    data_read_flag  = (state == RD);
    data_write_flag = (state == WR);
    data_addr       = 32'h0;
    val             = 32'h0;
    if ((state == RD) || (state == WR))
      data_addr = {addr_q[31:WORD_IDX_W+2], word_idx, 2'b00};
    if (state == WR)
      val = merged;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed bench for load_store_unit with a small
// combinational-read, clocked-write data memory attached to the port.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        data_read_flag;
  logic        data_write_flag;
  logic [31:0] data_addr;
  logic [31:0] val;
  logic [31:0] read_out;

  logic [31:0] mem [0:31];
  int          checks;
  int          passed;
  int          overlap_cnt;

  load_store_unit #(.MEM_WORDS(32), .WORD_IDX_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .data_read_flag(data_read_flag),
    .data_write_flag(data_write_flag), .data_addr(data_addr), .val(val),
    .read_out(read_out)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: asynchronous read, write on the rising edge.
  assign read_out = mem[data_addr[6:2]];
  always @(posedge clk) begin
    if (data_write_flag) mem[data_addr[6:2]] <= val;
  end

  // Flag overlap monitor
  always @(negedge clk) begin
    if (data_read_flag && data_write_flag) overlap_cnt++;
  end

  // Driver: present one request, wait for acceptance, then watch up to 8 cycles.
  task automatic run_req(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int rd_cnt, output int wr_cnt,
                         output logic [31:0] wv, output logic [31:0] ra,
                         output logic [31:0] rdata, output logic err);
    lat = 0; rd_cnt = 0; wr_cnt = 0; wv = 32'h0; ra = 32'h0; rdata = 32'h0; err = 1'b0;
    @(negedge clk);
    req_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (data_read_flag)  begin rd_cnt++; ra = data_addr; end
      if (data_write_flag) begin wr_cnt++; wv = val; end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passed++;
    checks++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid); else passed++;
    checks++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err got %b want 0", resp_err); else passed++;
    checks++; if (resp_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 0", resp_rdata); else passed++;
    checks++; if ({data_read_flag, data_write_flag} !== 2'b00) $display("FAIL reset_flags got %b want 00", {data_read_flag, data_write_flag}); else passed++;
    checks++; if (data_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", data_addr); else passed++;
    checks++; if (val !== 32'h0) $display("FAIL reset_val got %h want 0", val); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_load_word();
    int lat, rc, wc; logic [31:0] wv, ra, rd; logic er;
    run_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, rc, wc, wv, ra, rd, er);
    checks++; if (rc !== 1) $display("FAIL lw_rd_cycles got %0d want 1", rc); else passed++;
    checks++; if (ra !== 32'h0) $display("FAIL lw_addr got %h want 0", ra); else passed++;
    checks++; if (lat !== 2) $display("FAIL lw_latency got %0d want 2", lat); else passed++;
    checks++; if (rd !== 32'h0000000F) $display("FAIL lw_rdata got %h want 0000000f", rd); else passed++;
    checks++; if (er !== 1'b0) $display("FAIL lw_err got %b want 0", er); else passed++;
  endtask

  task automatic test_byte_ops();
    int lat, rc, wc; logic [31:0] wv, ra, rd; logic er;
    run_req(1'b0, 2'b00, 1'b1, 32'h4, 32'h0, lat, rc, wc, wv, ra, rd, er);
    checks++; if (rd !== 32'h0000000C) $display("FAIL lbu_rdata got %h want 0000000c", rd); else passed++;
    run_req(1'b1, 2'b00, 1'b0, 32'h9, 32'hAB, lat, rc, wc, wv, ra, rd, er);
    checks++; if ({rc, wc} !== {32'd1, 32'd1}) $display("FAIL sb_rd_wr_cycles got %0d,%0d want 1,1", rc, wc); else passed++;
    checks++; if (wv !== 32'h0000AB00) $display("FAIL sb_val got %h want 0000ab00", wv); else passed++;
    checks++; if (lat !== 3) $display("FAIL sb_latency got %0d want 3", lat); else passed++;
    checks++; if (rd !== 32'h0) $display("FAIL sb_rdata got %h want 0", rd); else passed++;
    run_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rc, wc, wv, ra, rd, er);
    checks++; if (rd !== 32'h0000AB00) $display("FAIL lw8_rdata got %h want 0000ab00", rd); else passed++;
  endtask

  task automatic test_half_ops();
    int lat, rc, wc; logic [31:0] wv, ra, rd; logic er;
    run_req(1'b1, 2'b01, 1'b0, 32'h12, 32'h8001, lat, rc, wc, wv, ra, rd, er);
    checks++; if (wv !== 32'h80010000) $display("FAIL sh_val got %h want 80010000", wv); else passed++;
    checks++; if (ra !== 32'h10) $display("FAIL sh_addr got %h want 00000010", ra); else passed++;
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, lat, rc, wc, wv, ra, rd, er);
    checks++; if (rd !== 32'hFFFF8001) $display("FAIL lh_rdata got %h want ffff8001", rd); else passed++;
    run_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, rc, wc, wv, ra, rd, er);
    checks++; if (rd !== 32'h00008001) $display("FAIL lhu_rdata got %h want 00008001", rd); else passed++;
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rc, wc, wv, ra, rd, er);
    checks++; if (rd !== 32'h80010000) $display("FAIL lw10_rdata got %h want 80010000", rd); else passed++;
  endtask

  task automatic test_errors();
    logic        e_st [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  e_sz [4] = '{2'b10, 2'b01, 2'b10, 2'b11};
    logic [31:0] e_ad [4] = '{32'h6, 32'h3, 32'h80, 32'h0};
    int lat, rc, wc; logic [31:0] wv, ra, rd; logic er;
    for (int i = 0; i < 4; i++) begin
      run_req(e_st[i], e_sz[i], 1'b0, e_ad[i], 32'h5A5A5A5A, lat, rc, wc, wv, ra, rd, er);
      checks++; if (er !== 1'b1) $display("FAIL err%0d_flag got %b want 1", i, er); else passed++;
      checks++; if (lat !== 1) $display("FAIL err%0d_latency got %0d want 1", i, lat); else passed++;
      checks++; if (rd !== 32'h0) $display("FAIL err%0d_rdata got %h want 0", i, rd); else passed++;
      checks++; if (rc + wc !== 0) $display("FAIL err%0d_mem_flags got %0d want 0", i, rc + wc); else passed++;
    end
  endtask

  task automatic test_reset_during_write();
    int lat, rc, wc; logic [31:0] wv, ra, rd; logic er;
    @(negedge clk);
    req_store = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h14; req_wdata = 32'hDEADBEEF; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (data_write_flag !== 1'b1) $display("FAIL sw_wr_flag got %b want 1", data_write_flag); else passed++;
    #1 rst = 1'b1;
    #1;
    checks++; if (data_write_flag !== 1'b0) $display("FAIL rst_wr_drop got %b want 0", data_write_flag); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL rst_idle got %b want 1", req_ready); else passed++;
    @(negedge clk);
    rst = 1'b0;
    run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, lat, rc, wc, wv, ra, rd, er);
    checks++; if (rd !== 32'h0) $display("FAIL lw14_rdata got %h want 0", rd); else passed++;
  endtask

  task automatic test_back_to_back();
    logic        rdy_a [1:6];
    logic        rv_a  [1:6];
    logic        rf_a  [1:6];
    logic        wf_a  [1:6];
    logic [31:0] ad_a  [1:6];
    logic [31:0] rd_a  [1:6];
    int lat, rc, wc; logic [31:0] wv, ra, rd; logic er;
    @(negedge clk);
    req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      rdy_a[c] = req_ready; rv_a[c] = resp_valid; rf_a[c] = data_read_flag;
      wf_a[c] = data_write_flag; ad_a[c] = data_addr; rd_a[c] = resp_rdata;
      if (c == 1) begin
        req_store = 1'b1; req_size = 2'b10; req_addr = 32'h0; req_wdata = 32'hFFFFFFFF;
      end
      if (c == 2) begin
        req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h4; req_wdata = 32'h0;
      end
      if (c == 5) req_valid = 1'b0;
    end
    checks++; if ({rdy_a[1], rdy_a[2], rdy_a[3]} !== 3'b001) $display("FAIL b2b_ready got %b want 001", {rdy_a[1], rdy_a[2], rdy_a[3]}); else passed++;
    checks++; if ({rv_a[2], rd_a[2]} !== {1'b1, 32'h0000000F}) $display("FAIL b2b_first_resp got %b/%h want 1/0000000f", rv_a[2], rd_a[2]); else passed++;
    checks++; if ({rf_a[4], ad_a[4]} !== {1'b1, 32'h4}) $display("FAIL b2b_second_rd got %b/%h want 1/00000004", rf_a[4], ad_a[4]); else passed++;
    checks++; if ({rv_a[5], rd_a[5]} !== {1'b1, 32'h0000000C}) $display("FAIL b2b_second_resp got %b/%h want 1/0000000c", rv_a[5], rd_a[5]); else passed++;
    checks++; if ({wf_a[1], wf_a[2], wf_a[3], wf_a[4], wf_a[5], wf_a[6]} !== 6'b0) $display("FAIL b2b_no_write got %b want 000000", {wf_a[1], wf_a[2], wf_a[3], wf_a[4], wf_a[5], wf_a[6]}); else passed++;
    run_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, lat, rc, wc, wv, ra, rd, er);
    checks++; if (rd !== 32'h0000000F) $display("FAIL b2b_word0_intact got %h want 0000000f", rd); else passed++;
    checks++; if (overlap_cnt !== 0) $display("FAIL flag_overlap got %0d want 0", overlap_cnt); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; overlap_cnt = 0;
    rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[0] = 32'h0000000F;
    mem[1] = 32'h0000000C;
    test_reset();
    test_load_word();
    test_byte_ops();
    test_half_ops();
    test_errors();
    test_reset_during_write();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
